// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package ldm_stm_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Byte distance between consecutive word transfers
    localparam int WORD_BYTES = 4;

    // Register list width, popcount width (0..16) and byte-offset width (0..64)
    localparam int RLIST_W = 16;
    localparam int CNT_W   = 5;
    localparam int OFF_W   = 7;

endpackage

// File: rtl/ldm_stm_seq_pat_lod.sv
// Lowest-set-bit detector for the remaining register-list pattern.
module pat_lod
    import ldm_stm_seq_pkg::*;
(
    input  logic [RLIST_W-1:0] pat,
    output logic [3:0]         idx,
    output logic [RLIST_W-1:0] clr_mask,
    output logic               empty,
    output logic               single
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx = 4'd0;
        for (int i = RLIST_W - 1; i >= 0; i--) begin
            if (pat[i]) begin
                idx = 4'(i);
            end
        end
    end

    // Isolate the lowest set bit; a pattern with one bit has nothing left after clearing it
    always_comb begin
        clr_mask = pat & (~pat + 16'd1);
        empty    = (pat == '0);
        single   = !empty && ((pat & (pat - 16'd1)) == '0);
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: walks the register list lowest-first, one memory
// request per listed register, then strobes base writeback and completion.
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
#(
    parameter int AW = 32
)
(
    input  logic               CLK,
    input  logic               nRESET,
    input  logic               START,
    input  logic [RLIST_W-1:0] RLIST,
    input  logic               IR_P,
    input  logic               IR_U,
    input  logic               IR_W,
    input  logic               IR_L,
    input  logic [AW-1:0]      BASE,
    input  logic               MEM_ACK,
    input  logic               KILL,
    output logic               BUSY,
    output logic               PIPE_EN,
    output logic               DREQ,
    output logic               NRW,
    output logic [AW-1:0]      MEM_ADDR,
    output logic [3:0]         REG_ADDR,
    output logic               PC_LOAD,
    output logic               LAST,
    output logic               WB_EN,
    output logic [AW-1:0]      WB_VAL,
    output logic               DONE
);

    function automatic logic [CNT_W-1:0] popcount(input logic [RLIST_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < RLIST_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    state_t             state, state_nxt;
    logic [RLIST_W-1:0] pat_p1;
    logic [AW-1:0]      addr_p1;
    logic [AW-1:0]      wb_val_p1;
    logic               l_p1, w_p1, nz_p1;

    logic [3:0]         lod_idx;
    logic [RLIST_W-1:0] lod_clr;
    logic               lod_empty, lod_single;

    logic [CNT_W-1:0]   n_cnt;
    logic [OFF_W-1:0]   off;
    logic [AW-1:0]      off_ext, stride, start_addr, wb_val_nxt;
    logic               accept, in_xfer, in_fin;

    pat_lod u_lod (
        .pat      (pat_p1),
        .idx      (lod_idx),
        .clr_mask (lod_clr),
        .empty    (lod_empty),
        .single   (lod_single)
    );

    assign n_cnt   = popcount(RLIST);
    assign off     = {n_cnt, 2'b00};
    assign off_ext = AW'(off);
    assign stride  = AW'(WORD_BYTES);
    assign accept  = (state == ST_IDLE) && START && !KILL;
    assign in_xfer = (state == ST_XFER);
    assign in_fin  = (state == ST_FIN);

    // First transfer address and final base value for the four addressing modes
    always_comb begin
        unique case ({IR_P, IR_U})
            2'b01:   start_addr = BASE;
            2'b11:   start_addr = BASE + stride;
            2'b00:   start_addr = BASE - off_ext + stride;
            default: start_addr = BASE - off_ext;
        endcase
        wb_val_nxt = IR_U ? (BASE + off_ext) : (BASE - off_ext);
    end

    // State register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; KILL overrides every transition
    always_comb begin
        state_nxt = state;
        if (KILL) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        state_nxt = (RLIST != '0) ? ST_XFER : ST_FIN;
                    end
                end
                ST_XFER: begin
                    if ((MEM_ACK && lod_single) || lod_empty) begin
                        state_nxt = ST_FIN;
                    end
                end
                ST_FIN:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Instruction latch at accept, then consume one list bit per acknowledged transfer
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pat_p1    <= '0;
            addr_p1   <= '0;
            wb_val_p1 <= '0;
            l_p1      <= 1'b0;
            w_p1      <= 1'b0;
            nz_p1     <= 1'b0;
        end else if (accept) begin
            pat_p1    <= RLIST;
            addr_p1   <= start_addr;
            wb_val_p1 <= wb_val_nxt;
            l_p1      <= IR_L;
            w_p1      <= IR_W;
            nz_p1     <= (RLIST != '0);
        end else if (in_xfer && MEM_ACK && !KILL) begin
            pat_p1    <= pat_p1 & ~lod_clr;
            addr_p1   <= addr_p1 + stride;
        end
    end

    // Outputs decoded from registered state; an abort suppresses the completion strobes
    always_comb begin
        BUSY     = (state != ST_IDLE);
        PIPE_EN  = !in_xfer;
        DREQ     = in_xfer;
        NRW      = in_xfer && !l_p1;
        MEM_ADDR = addr_p1;
        REG_ADDR = in_xfer ? lod_idx : 4'd0;
        PC_LOAD  = in_xfer && l_p1 && (lod_idx == 4'd15);
        LAST     = in_xfer && lod_single;
        DONE     = in_fin && !KILL;
        WB_EN    = in_fin && !KILL && w_p1 && nz_p1;
        WB_VAL   = wb_val_p1;
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for the LDM/STM sequencer.
module tb_ldm_stm_seq;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        START;
    logic [15:0] RLIST;
    logic        IR_P, IR_U, IR_W, IR_L;
    logic [31:0] BASE;
    logic        MEM_ACK;
    logic        KILL;
    logic        BUSY, PIPE_EN, DREQ, NRW, PC_LOAD, LAST, WB_EN, DONE;
    logic [31:0] MEM_ADDR, WB_VAL;
    logic [3:0]  REG_ADDR;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
        logic        nrw;
        logic        pc;
        logic        last;
    } xfer_t;

    typedef struct {
        logic        wb_en;
        logic [31:0] wb_val;
    } cmpl_t;

    xfer_t xq[$];
    cmpl_t cq[$];
    int    n_cmp = 0;
    int    n_err = 0;

    ldm_stm_seq #(.AW(32)) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .START    (START),
        .RLIST    (RLIST),
        .IR_P     (IR_P),
        .IR_U     (IR_U),
        .IR_W     (IR_W),
        .IR_L     (IR_L),
        .BASE     (BASE),
        .MEM_ACK  (MEM_ACK),
        .KILL     (KILL),
        .BUSY     (BUSY),
        .PIPE_EN  (PIPE_EN),
        .DREQ     (DREQ),
        .NRW      (NRW),
        .MEM_ADDR (MEM_ADDR),
        .REG_ADDR (REG_ADDR),
        .PC_LOAD  (PC_LOAD),
        .LAST     (LAST),
        .WB_EN    (WB_EN),
        .WB_VAL   (WB_VAL),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"},     32'(BUSY),     32'd0);
        chk({tag, "_pipe_en"},  32'(PIPE_EN),  32'd1);
        chk({tag, "_dreq"},     32'(DREQ),     32'd0);
        chk({tag, "_nrw"},      32'(NRW),      32'd0);
        chk({tag, "_mem_addr"}, MEM_ADDR,      32'd0);
        chk({tag, "_reg_addr"}, 32'(REG_ADDR), 32'd0);
        chk({tag, "_pc_load"},  32'(PC_LOAD),  32'd0);
        chk({tag, "_last"},     32'(LAST),     32'd0);
        chk({tag, "_wb_en"},    32'(WB_EN),    32'd0);
        chk({tag, "_wb_val"},   WB_VAL,        32'd0);
        chk({tag, "_done"},     32'(DONE),     32'd0);
    endtask

    // Reference model: expected transfer sequence and completion record
    task automatic model_push(input logic [15:0] rl, input logic p, input logic u,
                              input logic w, input logic l, input logic [31:0] base,
                              input bit push_cmpl, output int n);
        logic [31:0] off;
        logic [31:0] addr;
        int          k;
        xfer_t       e;
        cmpl_t       c;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(rl[i]);
        off = 32'(n * 4);
        if (!p && u)      addr = base;
        else if (p && u)  addr = base + 32'd4;
        else if (!p)      addr = base - off + 32'd4;
        else              addr = base - off;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                e.r    = 4'(i);
                e.a    = addr;
                e.nrw  = !l;
                e.pc   = l && (i == 15);
                e.last = (k == n - 1);
                xq.push_back(e);
                addr = addr + 32'd4;
                k++;
            end
        end
        if (push_cmpl) begin
            c.wb_en  = w && (n != 0);
            c.wb_val = u ? base + off : base - off;
            cq.push_back(c);
        end
    endtask

    // Monitor: compare every request cycle and every completion against the queues
    always @(negedge CLK) begin
        if (nRESET === 1'b1) begin
            if (DREQ) begin
                if (xq.size() == 0) begin
                    chk("unexp_dreq", 32'd1, 32'd0);
                end else begin
                    chk("reg_addr", 32'(REG_ADDR), 32'(xq[0].r));
                    chk("mem_addr", MEM_ADDR, xq[0].a);
                    chk("nrw", 32'(NRW), 32'(xq[0].nrw));
                    chk("pc_load", 32'(PC_LOAD), 32'(xq[0].pc));
                    chk("last", 32'(LAST), 32'(xq[0].last));
                    chk("pipe_en_xfer", 32'(PIPE_EN), 32'd0);
                    chk("busy_xfer", 32'(BUSY), 32'd1);
                    if (MEM_ACK) void'(xq.pop_front());
                end
            end
            if (DONE || WB_EN) begin
                if (cq.size() == 0) begin
                    chk("unexp_done", 32'd1, 32'd0);
                end else begin
                    chk("done", 32'(DONE), 32'd1);
                    chk("wb_en", 32'(WB_EN), 32'(cq[0].wb_en));
                    chk("wb_val", WB_VAL, cq[0].wb_val);
                    chk("pipe_en_fin", 32'(PIPE_EN), 32'd1);
                    void'(cq.pop_front());
                end
            end
        end
    end

    // Issue one instruction; optional stall of st_len cycles on transfer st_idx,
    // optional stray START pulse at cycle glitch (0 = none)
    task automatic do_op(input logic [15:0] rl, input logic p, input logic u,
                         input logic w, input logic l, input logic [31:0] base,
                         input int st_idx, input int st_len, input int glitch);
        int n;
        int exp_cyc;
        int c;
        int acks;
        int stalled;
        bit done;
        @(posedge CLK); #1;
        START = 1'b1; RLIST = rl; IR_P = p; IR_U = u; IR_W = w; IR_L = l;
        BASE = base; MEM_ACK = 1'b1;
        @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_pipe_en", 32'(PIPE_EN), 32'd1);
        chk("xq_drained", 32'(xq.size()), 32'd0);
        chk("cq_drained", 32'(cq.size()), 32'd0);
        model_push(rl, p, u, w, l, base, 1'b1, n);
        exp_cyc = (n == 0) ? 1 : n + 1 + ((st_idx >= 0 && st_idx < n) ? st_len : 0);
        c = 1; acks = 0; stalled = 0; done = 0;
        while (!done && c <= 60) begin
            @(posedge CLK); #1;
            START = (c == glitch);
            if (c == glitch) begin
                RLIST = 16'hFFFF;
                BASE  = 32'h0BAD_0000;
            end
            MEM_ACK = !(acks == st_idx && stalled < st_len);
            if (!MEM_ACK) stalled++;
            @(negedge CLK);
            if (DREQ && MEM_ACK) acks++;
            if (DONE) begin
                done = 1;
                chk("done_cycle", 32'(c), 32'(exp_cyc));
            end
            c++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        START = 1'b0;
        MEM_ACK = 1'b1;
    endtask

    initial begin
        int n;
        nRESET = 1'b0; START = 1'b0; RLIST = '0; IR_P = 1'b0; IR_U = 1'b0;
        IR_W = 1'b0; IR_L = 1'b0; BASE = '0; MEM_ACK = 1'b1; KILL = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_rst("rst");
        @(posedge CLK); #3;
        nRESET = 1'b1;

        // LDMIA r0!, {r1,r3,r15}
        do_op(16'h800A, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, -1, 0, 0);
        // STMDB r13!, {r4-r7}
        do_op(16'h00F0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000, -1, 0, 0);
        // LDMIB without writeback, address wraps
        do_op(16'h0003, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, -1, 0, 0);
        // STMIA with a two-cycle stall on the second transfer
        do_op(16'h0006, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 1, 2, 0);
        // Empty list with writeback requested
        do_op(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3800, -1, 0, 0);
        // LDMDA all registers, stray START during XFER must be ignored
        do_op(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_4000, -1, 0, 2);
        // Random instructions
        for (int k = 0; k < 4; k++) begin
            do_op(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom, (k == 1) ? 0 : -1, 1, 0);
        end

        // KILL during the second of four transfers
        @(posedge CLK); #1;
        START = 1'b1; RLIST = 16'h0F00; IR_P = 1'b0; IR_U = 1'b1; IR_W = 1'b1;
        IR_L = 1'b0; BASE = 32'h0000_5000; MEM_ACK = 1'b1;
        @(negedge CLK);
        model_push(16'h0F00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 1'b0, n);
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        KILL = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        KILL = 1'b0;
        @(negedge CLK);
        chk("kill_busy", 32'(BUSY), 32'd0);
        chk("kill_pipe_en", 32'(PIPE_EN), 32'd1);
        chk("kill_dreq", 32'(DREQ), 32'd0);
        chk("kill_left", 32'(xq.size()), 32'd2);
        xq.delete();
        repeat (3) @(negedge CLK);

        // Asynchronous reset in the middle of a transfer
        do_op(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_5800, -1, 0, 0);
        @(posedge CLK); #1;
        START = 1'b1; RLIST = 16'h00F0; IR_P = 1'b0; IR_U = 1'b1; IR_W = 1'b1;
        IR_L = 1'b1; BASE = 32'h0000_6000; MEM_ACK = 1'b1;
        @(negedge CLK);
        model_push(16'h00F0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_6000, 1'b0, n);
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        nRESET = 1'b0;
        #1;
        chk_rst("midrst");
        chk("rst_left", 32'(xq.size()), 32'd2);
        xq.delete();
        @(posedge CLK); #3;
        nRESET = 1'b1;

        // Normal operation resumes after reset
        do_op(16'h4001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_7000, -1, 0, 0);
        @(negedge CLK);
        chk("final_xq", 32'(xq.size()), 32'd0);
        chk("final_cq", 32'(cq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Multi-cycle sequencer for ARM block transfers (LDM/STM). It latches a decoded block-transfer instruction from ID, walks the 16-bit register list lowest-register-first, and issues one data-memory request per listed register with the correct word address. It computes the base-register writeback value and freezes the F/D pipeline until the transfer completes. It sits between ID control and EX1/data-memory request logic and replaces the per-cycle pattern feedback loop through ID with a self-contained state machine.

## Interface
Parameters:
- AW, 32, address/data width of base and memory address.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- START  in  1  valid LDM/STM present in ID; accepted only in IDLE.
- RLIST  in  16  register list, bit i = register i.
- IR_P  in  1  pre-index (before) when 1.
- IR_U  in  1  up (increment) when 1.
- IR_W  in  1  base writeback enable.
- IR_L  in  1  1 = load (LDM), 0 = store (STM).
- BASE  in  AW  base register value at START.
- MEM_ACK  in  1  data memory accepts current request this cycle.
- KILL  in  1  flush/interrupt abort; highest priority.
- BUSY  out  1  sequencer not in IDLE.
- PIPE_EN  out  1  F/D pipeline enable (0 = freeze).
- DREQ  out  1  data memory request.
- NRW  out  1  1 = write (STM), 0 = read (LDM); valid while DREQ.
- MEM_ADDR  out  AW  word address of current transfer.
- REG_ADDR  out  4  register index of current transfer.
- PC_LOAD  out  1  current transfer is LDM of r15.
- LAST  out  1  current transfer is the final one.
- WB_EN  out  1  one-cycle base writeback strobe.
- WB_VAL  out  AW  new base value; valid when WB_EN.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, XFER, FIN.
- IDLE: PIPE_EN=1. START=1 latches RLIST, P, U, W, L, BASE. Non-empty list goes to XFER; empty list goes to FIN.
- n = popcount(RLIST), 5 bits (0..16). off = 4*n, 7 bits, zero-extended to AW.
- Start address: IA (P=0,U=1) = BASE; IB (P=1,U=1) = BASE+4; DA (P=0,U=0) = BASE-off+4; DB (P=1,U=0) = BASE-off. All arithmetic is modulo 2^AW.
- Writeback value: U ? BASE+off : BASE-off. Computed at START and held.
- XFER: DREQ=1, NRW=~L. REG_ADDR = index of the lowest set bit of the remaining pattern. MEM_ADDR = running address. LAST=1 when one bit remains. PC_LOAD = L & (REG_ADDR==15).
  - On MEM_ACK: clear that bit and add 4 to the address. If LAST, go to FIN.
  - While MEM_ACK=0: all outputs hold.
- FIN: DONE=1, WB_EN=W & (n!=0), PIPE_EN=1. Then go to IDLE. An empty list produces no DREQ and no writeback.
- KILL in any state: go to IDLE next cycle. No DONE and no WB_EN. A transfer acked in the same cycle as KILL is counted as complete by memory, but the sequencer still aborts.
- START while BUSY is ignored.

## Timing
- Reset values: state IDLE; BUSY 0, PIPE_EN 1, DREQ 0, NRW 0, MEM_ADDR 0, REG_ADDR 0, PC_LOAD 0, LAST 0, WB_EN 0, WB_VAL 0, DONE 0.
- START sampled in cycle 0; first DREQ in cycle 1. All request outputs are registered.
- With MEM_ACK held at 1: DREQ in cycles 1..n, FIN in cycle n+1, IDLE in cycle n+2. An empty list gives FIN in cycle 1.
- PIPE_EN = 0 in XFER only. The next instruction may present START in the cycle after FIN.
- Each MEM_ACK low cycle stretches XFER by exactly one cycle.
- nRESET asserted mid-operation: immediate return to reset values. No DONE and no WB_EN.

## Structure
- Shared include ldm_stm_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_XFER=2'd1, ST_FIN=2'd2;
  - word stride constant WORD_BYTES=4.
- One sub-module, pat_lod: combinational lowest-set-bit detector, 16-bit pattern in. Outputs are a 4-bit index, a one-hot clear mask, an empty flag and a "single bit left" flag.
- Popcount and address adders live in the top level.

## Test plan
- LDMIA r0!, {r1,r3,r15}, BASE=0x1000, ACK=1 -> REG_ADDR 1,3,15 at MEM_ADDR 0x1000, 0x1004, 0x1008. NRW=0; PC_LOAD only on the third transfer; LAST on the third. Cycle 4: DONE=1, WB_EN=1, WB_VAL=0x100C.
- STMDB r13!, RLIST=0x00F0, BASE=0x2000 -> REG_ADDR 4..7 at 0x1FF0, 0x1FF4, 0x1FF8, 0x1FFC. NRW=1; WB_VAL=0x1FF0.
- LDMIB, RLIST=0x0003, BASE=0xFFFFFFF8, W=0 -> addresses 0xFFFFFFFC then 0x00000000 (wrap). WB_EN stays 0.
- STMIA, RLIST=0x0006, MEM_ACK low for 2 cycles on the second transfer -> REG_ADDR=2 and its address held 3 cycles. DONE arrives 2 cycles later than the no-stall case; PIPE_EN=0 throughout XFER.
- RLIST=0x0000, W=1 -> no DREQ ever. DONE in cycle 1 with WB_EN=0. START during XFER of another instruction has no effect.
- KILL asserted during the second of four transfers -> IDLE next cycle, no DONE, no WB_EN, PIPE_EN=1. Separately, nRESET low mid-XFER -> all outputs at reset values immediately.
